// File: rtl/nbbpu_exec_unit.sv
// -----------------------------------------------------------------------------
// nbbpu_exec_unit
//
// Control and execute core of the NBBPU 16-bit CPU. It contains a four-state
// cycle FSM (FETCH, DECODE, EXECUTE, STORE), the opcode decoder that produces
// the memory and register-file strobes, a combinational ALU, and the program
// counter register. The register file, memories and operand muxing live
// outside this block.
//
// Instruction fields: opcode = instruction[15:12], x = [11:8], y = [7:4],
// z = [3:0].
//
// Ports:
//   clock              in   CPU clock, rising edge active
//   reset              in   asynchronous, active-high reset
//   instruction[15:0]  in   current instruction from ROM
//   X[15:0]            in   register operand x (also RAM address outside)
//   Y[15:0]            in   register operand y
//   read_data[15:0]    in   RAM read data
//   state[1:0]         out  00 FETCH, 01 DECODE, 10 EXECUTE, 11 STORE
//   instruction_enable out  ROM read strobe
//   read_enable        out  RAM read strobe
//   write_enable       out  RAM write strobe (write data is Z)
//   reg_write          out  register file write of Z into reg z
//   reg_set            out  SEL/SEU: external mux routes reg z to x read port
//   PC[15:0]           out  program counter
//   Z[15:0]            out  ALU result
//   pass               out  (only with NBBPU_PASS_DETECT_EN) sticky flag set
//                           when 42 is stored to address 0xFFF0
//
// Optional feature macro: NBBPU_PASS_DETECT_EN
// -----------------------------------------------------------------------------
module nbbpu_exec_unit #(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [15:0]      instruction,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic [WIDTH-1:0] read_data,
   output logic [1:0]       state,
   output logic             instruction_enable,
   output logic             read_enable,
   output logic             write_enable,
   output logic             reg_write,
   output logic             reg_set,
   output logic [WIDTH-1:0] PC,
   output logic [WIDTH-1:0] Z
`ifdef NBBPU_PASS_DETECT_EN
   ,
   output logic             pass
`endif
);

   typedef enum logic [1:0] {
      FETCH   = 2'b00,
      DECODE  = 2'b01,
      EXECUTE = 2'b10,
      STORE   = 2'b11
   } state_t;

   typedef enum logic [3:0] {
      OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_IOR = 4'h3,
      OP_XOR = 4'h4, OP_SHR = 4'h5, OP_SHL = 4'h6, OP_CMP = 4'h7,
      OP_JMP = 4'h8, OP_BRZ = 4'h9, OP_BRN = 4'hA, OP_RES = 4'hB,
      OP_LOD = 4'hC, OP_STR = 4'hD, OP_SEL = 4'hE, OP_SEU = 4'hF
   } opcode_t;

   state_t           state_q;
   state_t           state_d;
   opcode_t          opcode;
   logic             take_jump;
   logic [WIDTH-1:0] pc_next;
   logic [WIDTH-1:0] pc_inc;

   assign opcode = opcode_t'(instruction[15:12]);
   assign state  = state_q;
   assign pc_inc = PC + WIDTH'(1);

   // ---------------------------------------------------------------------------
   // Cycle FSM: unconditional four-step sequence, one clock per state.
   // ---------------------------------------------------------------------------
   // NOTE: registers are written with non-blocking assignments so every flop
   // samples the pre-edge value of its inputs regardless of block ordering.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every output of this combinational block gets a default first, so
   // no path through the case statement can leave a signal unassigned (which
   // would infer a latch).
   always_comb begin
      state_d            = FETCH;
      instruction_enable = 1'b0;
      read_enable        = 1'b0;
      write_enable       = 1'b0;
      reg_write          = 1'b0;
      unique case (state_q)
         FETCH: begin
            state_d            = DECODE;
            instruction_enable = 1'b1;
         end
         DECODE: begin
            state_d = EXECUTE;
         end
         EXECUTE: begin
            state_d     = STORE;
            read_enable = (opcode == OP_LOD);
         end
         STORE: begin
            state_d      = FETCH;
            read_enable  = (opcode == OP_LOD);
            write_enable = (opcode == OP_STR);
            // Branches, RES and STR produce no register result.
            reg_write    = !(opcode inside {OP_BRZ, OP_BRN, OP_RES, OP_STR});
         end
         default: state_d = FETCH;
      endcase
   end

   // reg_set steers the external x-port mux during the whole instruction, so
   // it depends on the opcode only, not on the state.
   assign reg_set = (opcode == OP_SEL) || (opcode == OP_SEU);

   // ---------------------------------------------------------------------------
   // Program counter: advances only on the edge leaving STORE.
   // ---------------------------------------------------------------------------
   always_comb begin
      take_jump = 1'b0;
      unique case (opcode)
         OP_JMP:  take_jump = 1'b1;
         OP_BRZ:  take_jump = (Y == '0);
         OP_BRN:  take_jump = (Y != '0);
         default: take_jump = 1'b0;
      endcase
   end

   assign pc_next = take_jump ? X : pc_inc;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         PC <= '0;
      end else if (state_q == STORE) begin
         PC <= pc_next;
      end
   end

   // ---------------------------------------------------------------------------
   // ALU: purely combinational, modulo 2^16, carries and overflow dropped.
   // Shifts use only Y[3:0], so the amount is always 0..15.
   // ---------------------------------------------------------------------------
   always_comb begin
      Z = '0;
      unique case (opcode)
         OP_ADD:  Z = X + Y;
         OP_SUB:  Z = X - Y;
         OP_AND:  Z = X & Y;
         OP_IOR:  Z = X | Y;
         OP_XOR:  Z = X ^ Y;
         OP_SHR:  Z = X >> Y[3:0];
         OP_SHL:  Z = X << Y[3:0];
         OP_CMP:  Z = (X == Y) ? WIDTH'(1) : '0;
         OP_JMP:  Z = pc_inc;                      // link address
         OP_BRZ,
         OP_BRN,
         OP_RES:  Z = '0;
         OP_LOD:  Z = read_data;
         OP_STR:  Z = Y;
         OP_SEL:  Z = {X[15:8], instruction[11:4]}; // replace low byte
         OP_SEU:  Z = {instruction[11:4], X[7:0]};  // replace high byte
         default: Z = '0;
      endcase
   end

`ifdef NBBPU_PASS_DETECT_EN
   // ---------------------------------------------------------------------------
   // Pass detector: a program signals success by storing 42 to 0xFFF0. The
   // flag is sticky until reset.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pass <= 1'b0;
      end else if ((state_q == STORE) && write_enable &&
                   (X == 16'hFFF0) && (Z == 16'd42)) begin
         pass <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_nbbpu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_nbbpu_exec_unit
//
// Directed testbench for nbbpu_exec_unit. Each instruction is driven for one
// full four-cycle pass; expected values are pushed to a scoreboard queue as the
// stimulus is applied and popped when the corresponding DUT output is sampled
// (on the falling edge, away from the active rising edge).
// -----------------------------------------------------------------------------
module tb_nbbpu_exec_unit;

   logic        clock;
   logic        reset;
   logic [15:0] instruction;
   logic [15:0] X;
   logic [15:0] Y;
   logic [15:0] read_data;
   logic [1:0]  state;
   logic        instruction_enable;
   logic        read_enable;
   logic        write_enable;
   logic        reg_write;
   logic        reg_set;
   logic [15:0] PC;
   logic [15:0] Z;
`ifdef NBBPU_PASS_DETECT_EN
   logic        pass;
`endif

   int          tests_run;
   int          tests_failed;
   logic [15:0] sb_q[$];

   nbbpu_exec_unit #(.WIDTH(16)) dut (
      .clock              (clock),
      .reset              (reset),
      .instruction        (instruction),
      .X                  (X),
      .Y                  (Y),
      .read_data          (read_data),
      .state              (state),
      .instruction_enable (instruction_enable),
      .read_enable        (read_enable),
      .write_enable       (write_enable),
      .reg_write          (reg_write),
      .reg_set            (reg_set),
      .PC                 (PC),
      .Z                  (Z)
`ifdef NBBPU_PASS_DETECT_EN
      ,
      .pass               (pass)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Pop the oldest expected value and compare it with the observed one.
   task automatic check(input string tag, input logic [15:0] observed);
      logic [15:0] expected;
      tests_run++;
      if (sb_q.size() == 0) begin
         tests_failed++;
         $error("FAIL %s: observed=%h but scoreboard empty", tag, observed);
      end else begin
         expected = sb_q.pop_front();
         assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
         end
      end
   endtask

   // Strobe vector in a fixed order: {ie, re, we, rw, rs}.
   function automatic logic [15:0] strobes();
      return {11'b0, instruction_enable, read_enable, write_enable,
              reg_write, reg_set};
   endfunction

   // Expected strobes for a given opcode and state, straight from the opcode
   // table: ROM read in FETCH, RAM read in EXECUTE/STORE for LOD, RAM write in
   // STORE for STR, register write in STORE for 0-8/C/E/F, reg_set for E/F.
   function automatic logic [15:0] exp_strobes(input logic [3:0] op,
                                               input int s);
      logic ie, re, we, rw, rs;
      ie = (s == 0);
      re = (op == 4'hC) && (s == 2 || s == 3);
      we = (op == 4'hD) && (s == 3);
      rw = (s == 3) && (op <= 4'h8 || op == 4'hC || op == 4'hE || op == 4'hF);
      rs = (op == 4'hE || op == 4'hF);
      return {11'b0, ie, re, we, rw, rs};
   endfunction

   // Run one instruction starting at a falling edge in FETCH. Checks state and
   // strobes every cycle, Z in STORE, and PC once back in FETCH.
   task automatic run_instr(input string name, input logic [15:0] ins,
                            input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] rd, input logic [15:0] exp_z,
                            input logic [15:0] exp_pc);
      instruction = ins;
      X           = x;
      Y           = y;
      read_data   = rd;
      #1;
      for (int s = 0; s < 4; s++) begin
         sb_q.push_back(16'(s));
         check({name, ".state"}, {14'b0, state});
         sb_q.push_back(exp_strobes(ins[15:12], s));
         check({name, ".strobes"}, strobes());
         if (s == 3) begin
            sb_q.push_back(exp_z);
            check({name, ".Z"}, Z);
         end
         @(negedge clock);
         #1;
      end
      sb_q.push_back(exp_pc);
      check({name, ".PC"}, PC);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b1;
      instruction  = 16'hB000;
      X            = '0;
      Y            = '0;
      read_data    = '0;

      // Reset state.
      repeat (2) @(negedge clock);
      sb_q.push_back(16'h0000);
      check("reset.state", {14'b0, state});
      sb_q.push_back(16'h0000);
      check("reset.PC", PC);
      sb_q.push_back(16'h0010);
      check("reset.strobes", strobes());
`ifdef NBBPU_PASS_DETECT_EN
      sb_q.push_back(16'h0000);
      check("reset.pass", {15'b0, pass});
`endif
      reset = 1'b0;

      // Five RES no-ops bring PC to 5.
      for (int i = 0; i < 5; i++) begin
         run_instr("res", 16'hB000, 16'h1111, 16'h2222, 16'h0, 16'h0000,
                   16'(i + 1));
      end

      // Asynchronous reset in the middle of EXECUTE.
      @(negedge clock);
      @(negedge clock);
      sb_q.push_back(16'h0002);
      check("mid.state", {14'b0, state});
      sb_q.push_back(16'h0005);
      check("mid.PC", PC);
      reset = 1'b1;
      #1;
      sb_q.push_back(16'h0000);
      check("async.state", {14'b0, state});
      sb_q.push_back(16'h0000);
      check("async.PC", PC);
      @(negedge clock);
      reset = 1'b0;

      // ALU operations.
      run_instr("add", 16'h0123, 16'h7FFF, 16'h0001, 16'h0, 16'h8000, 16'h0001);
      run_instr("sub", 16'h1123, 16'h0000, 16'h0001, 16'h0, 16'hFFFF, 16'h0002);
      run_instr("shl", 16'h6123, 16'h0001, 16'h0013, 16'h0, 16'h0008, 16'h0003);
      run_instr("shr", 16'h5123, 16'h8000, 16'h0004, 16'h0, 16'h0800, 16'h0004);
      run_instr("shl0", 16'h6123, 16'hABCD, 16'h0010, 16'h0, 16'hABCD, 16'h0005);
      run_instr("sel", 16'hEA50, 16'h1234, 16'h0000, 16'h0, 16'h12A5, 16'h0006);
      run_instr("seu", 16'hF3C0, 16'h1234, 16'h0000, 16'h0, 16'h3C34, 16'h0007);
      run_instr("cmp_eq", 16'h7123, 16'h0005, 16'h0005, 16'h0, 16'h0001, 16'h0008);
      run_instr("cmp_ne", 16'h7123, 16'h0005, 16'h0006, 16'h0, 16'h0000, 16'h0009);

      // Jumps and branches.
      run_instr("jmp10", 16'h8000, 16'h0010, 16'h0000, 16'h0, 16'h000A, 16'h0010);
      run_instr("jmp40", 16'h8000, 16'h0040, 16'h0000, 16'h0, 16'h0011, 16'h0040);
      run_instr("brz_t", 16'h9000, 16'h0080, 16'h0000, 16'h0, 16'h0000, 16'h0080);
      run_instr("brz_n", 16'h9000, 16'h0100, 16'h0003, 16'h0, 16'h0000, 16'h0081);
      run_instr("brn_t", 16'hA000, 16'h0200, 16'h0003, 16'h0, 16'h0000, 16'h0200);
      run_instr("brn_n", 16'hA000, 16'h0300, 16'h0000, 16'h0, 16'h0000, 16'h0201);

      // Memory operations.
      run_instr("lod", 16'hC000, 16'h0020, 16'h0000, 16'hBEEF, 16'hBEEF, 16'h0202);
      run_instr("str", 16'hD000, 16'hFFF0, 16'd42, 16'h0, 16'd42, 16'h0203);
`ifdef NBBPU_PASS_DETECT_EN
      sb_q.push_back(16'h0001);
      check("pass", {15'b0, pass});
`endif

      // PC wrap from 0xFFFF to 0x0000.
      run_instr("jmpff", 16'h8000, 16'hFFFF, 16'h0000, 16'h0, 16'h0204, 16'hFFFF);
      run_instr("wrap", 16'h0123, 16'h0001, 16'h0002, 16'h0, 16'h0003, 16'h0000);

      // Remaining logic operations.
      run_instr("and", 16'h2123, 16'hF0F0, 16'h3C3C, 16'h0, 16'h3030, 16'h0001);
      run_instr("ior", 16'h3123, 16'hF0F0, 16'h3C3C, 16'h0, 16'hFCFC, 16'h0002);
      run_instr("xor", 16'h4123, 16'hF0F0, 16'h3C3C, 16'h0, 16'hCCCC, 16'h0003);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
